// File: rtl/glip_channel_arbiter_pkg.sv
// Shared types and helpers for the GLIP outgoing-channel packet arbiter.
package glip_channel_arbiter_pkg;

  // Upper bound on requesters; index vectors are sized for this many ports.
  localparam int MAX_PORTS = 16;
  localparam int IDX_W     = 4;

  // Channel ownership state: free, waiting for the length header, streaming payload.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // Index of the set bit in a one-hot vector (zero when the vector is empty).
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_PORTS-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/glip_rr_picker.sv
// Round-robin picker: first requesting port strictly after last_grant, wrapping.
module glip_rr_picker
  import glip_channel_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [NUM_PORTS-1:0] pick_o,
  output logic                 found_o
);

  // Walk the ports in priority order starting one past the previous winner.
  always_comb begin
    logic hit;
    int   idx;
    hit    = 1'b0;
    idx    = 0;
    pick_o = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_PORTS;
      if (!hit && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        hit         = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/glip_channel_arbiter.sv
// Packet-level round-robin arbiter sharing one GLIP fifo_out channel among
// several logic-side requesters. A packet is a length header followed by that
// many payload words; the owner keeps the channel until its packet completes.
module glip_channel_arbiter
  import glip_channel_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_PORTS = 2
) (
  input  logic                       clk_logic,
  input  logic                       rst_n,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]       in_valid,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       busy
);

  state_e               state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [WIDTH-1:0]     count_q;

  logic [NUM_PORTS-1:0] pick_d;
  logic                 found_d;
  logic [MAX_PORTS-1:0] pick_ext;
  logic [IDX_W-1:0]     last_grant_d;

  logic [WIDTH-1:0]     sel_data;
  logic                 sel_valid;
  logic                 active;
  logic                 xfer;

  glip_rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req_i        (in_valid),
    .last_grant_i (last_grant_q),
    .pick_o       (pick_d),
    .found_o      (found_d)
  );

  // Widen the pick to the package vector size so the index helper can encode it.
  always_comb begin
    pick_ext                = '0;
    pick_ext[NUM_PORTS-1:0] = pick_d;
    last_grant_d            = onehot_to_index(pick_ext);
  end

  // One-hot AND-OR mux of the owner's data and valid; grant is zero in IDLE.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        sel_data  = in_data[i*WIDTH +: WIDTH];
        sel_valid = in_valid[i];
      end
    end
  end

  assign active    = (state_q != IDLE);
  assign out_valid = sel_valid && active;
  assign out_data  = sel_data;
  assign in_ready  = grant_q & {NUM_PORTS{out_ready && active}};
  assign grant     = grant_q;
  assign busy      = active;
  assign xfer      = out_valid && out_ready;

  // Ownership FSM: arbitrate in IDLE, capture length in HEADER, count down in PAYLOAD.
  always_ff @(posedge clk_logic) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      count_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q      <= pick_d;
            last_grant_q <= last_grant_d;
            state_q      <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) begin
            if (sel_data == '0) begin
              state_q <= IDLE;
              grant_q <= '0;
            end else begin
              count_q <= sel_data;
              state_q <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            count_q <= count_q - WIDTH'(1);
            // Exit on the last word so the counter never wraps below zero.
            if (count_q == WIDTH'(1)) begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/glip_channel_arbiter.md
Name: glip_channel_arbiter

Overview:
- Packet-level round-robin arbiter sharing one GLIP outgoing FIFO channel (host-bound stream) among NUM_PORTS logic-side requesters, e.g. several debug modules.
- Each packet is one header word holding the payload word count, followed by exactly that many payload words.
- A granted port owns the channel until its packet completes; words from different ports never interleave.
- Sits in the clk_logic domain, between the debug modules and the TCP/FPGA backend toplevel's fifo_out slave port.

Parameters:
- WIDTH, 16, data word width; the header's payload length uses all WIDTH bits, unsigned.
- NUM_PORTS, 2, number of requesters (2..16).

Ports:
- clk_logic  input  1  logic clock; all state on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on clk_logic rising edge.
- in_data  input  NUM_PORTS*WIDTH  per-port data; port i at bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_PORTS  per-port valid.
- in_ready  output  NUM_PORTS  per-port ready.
- out_data  output  WIDTH  to backend fifo_out.data.
- out_valid  output  1  to backend fifo_out.valid.
- out_ready  input  1  from backend fifo_out.ready.
- grant  output  NUM_PORTS  one-hot owner of the channel; all zero in IDLE.
- busy  output  1  high in HEADER or PAYLOAD.

Behaviour:
- Handshake: a word transfers on a rising edge where valid && ready. Once valid is raised, a source holds valid and data stable until the transfer.
- Reset (rst_n=0 at an edge):
  - state=IDLE, grant=0, busy=0, length counter=0.
  - last_grant pointer=NUM_PORTS-1, so port 0 has first priority.
  - Takes effect even mid-packet; the partial packet is abandoned and not resumed.
- Combinational outputs:
  - out_valid = in_valid[g] && state!=IDLE.
  - out_data = in_data[g], where g is the granted index.
  - in_ready[g] = out_ready && state!=IDLE.
  - in_ready of non-granted ports = 0 at all times; in_ready = 0 in IDLE.
  - out_data is don't-care when out_valid=0.
- IDLE:
  - Search from last_grant+1 upward, wrapping modulo NUM_PORTS, for the first port with in_valid=1.
  - If one is found: register grant, update last_grant, go to HEADER next cycle. This is a 1-cycle arbitration bubble; no transfer happens in IDLE.
  - If none is found, stay in IDLE.
- HEADER:
  - On transfer, capture the header word as len.
  - len==0: return to IDLE (header-only packet).
  - Otherwise load count=len and go to PAYLOAD.
- PAYLOAD:
  - On each transfer, count decrements.
  - A transfer with count==1 returns to IDLE and clears grant.
  - No transfer: hold state and count, so stalls on either side are unbounded.
- Ownership rules:
  - grant does not change while in HEADER or PAYLOAD, whatever the in_valid of other ports.
  - A deasserted in_valid from the owner mid-packet stalls the channel; no other port may take it.
- Throughput: a packet of L payload words needs L+1 transfer cycles plus 1 bubble. The same port is granted again only if no other port is requesting.
- Width rules:
  - count is WIDTH bits, so the maximum payload is 2^WIDTH-1 words.
  - count never wraps below 0, because the PAYLOAD exit happens at count==1.
- Simultaneous events: several requesters in IDLE resolve by round-robin order only. A transfer and a state exit in the same cycle are both honoured.

Decomposition:
- Package glip_channel_arbiter_pkg:
  - state enum {IDLE, HEADER, PAYLOAD} as a 2-bit typedef.
  - Function onehot_to_index.
- Sub-module glip_rr_picker (combinational):
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot pick and found flag.
  - Instantiated once; unit-testable separately.

Test Plan:
- Single packet, N=2, WIDTH=16: port0 sends 0x0003,0xA1,0xA2,0xA3 with out_ready=1 -> grant=01 from cycle 2, out stream 0x0003,0xA1,0xA2,0xA3 on cycles 2-5, IDLE on cycle 6, busy high exactly cycles 2-5.
- Contention, alternating: both ports continuously offer packets of length 2 -> grant sequence 01,10,01,10; no interleaved words; each packet is 3 contiguous transfers.
- Zero-length and maximum-length: port1 header 0x0000 -> one transfer, then IDLE. Header 0xFFFF followed by 65535 payload words -> exactly 65536 transfers; count does not wrap.
- Backpressure and source stall: out_ready toggling 1,0,0,1 plus in_valid from the owner dropping for 3 cycles mid-payload -> no lost or duplicated words, grant unchanged, port1 in_ready=0 throughout.
- Reset mid-packet: rst_n=0 for one edge after 2 of 5 payload words -> next cycle grant=0, busy=0, out_valid=0. If both ports then request, port0 wins first.
- Simultaneous requests after reset: both ports valid on the first cycle out of reset -> port0 granted, then port1; in_ready stays 0 in every IDLE cycle.
